// File: rtl/sodor5_iltype_stim_gen.sv
// sodor5_iltype_stim_gen: seeded, flow-controlled I-type ALU / load instruction
// source for the sodor5 lockstep harness. Issues WARMUP NOPs, then NUM_INSTR
// words derived from a 32-bit Galois LFSR, then parks in DONE emitting NOP.
// Optional feature macro: STIM_HAZARD_EN (forces RAW dependencies on ~25% of words).
//
// state  | meaning
// IDLE   | after reset, waiting for start, instr=NOP, valid=0
// WARMUP | issuing NOPs, one per accept
// GEN    | issuing LFSR-derived words, one per accept
// DONE   | run finished, instr=NOP, valid=0, start restarts
module sodor5_iltype_stim_gen #(
  parameter logic [31:0] SEED       = 32'd909,
  parameter int          NUM_INSTR  = 100,
  parameter int          WARMUP     = 2,
  parameter logic [2:0]  LD_F3_MASK = 3'b100
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] issued_count
);

  localparam logic [31:0] NOP       = 32'h00000013;
  localparam logic [31:0] TAPS      = 32'h80200003;
  localparam logic [31:0] SEED_INIT = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [31:0] NUM_U     = 32'(NUM_INSTR);
  localparam logic [31:0] WARM_U    = 32'(WARMUP);
  localparam logic [31:0] LAST_IDX  = NUM_U - 32'd1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WARMUP = 2'd1,
    S_GEN    = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] lfsr;
  logic [31:0] warm_cnt;
  logic [31:0] lfsr_next;
  logic [31:0] first_lfsr;
  logic [31:0] word_next;
  logic [31:0] first_word;
  logic        accept;

  function automatic logic [31:0] lfsr_step(input logic [31:0] r);
    return {1'b0, r[31:1]} ^ (r[0] ? TAPS : 32'd0);
  endfunction

`ifdef STIM_HAZARD_EN
  function automatic logic [31:0] make_word(input logic [31:0] r, input logic hz_ok,
                                            input logic [4:0] prev_rd);
`else
  function automatic logic [31:0] make_word(input logic [31:0] r);
`endif
    logic [11:0] imm;
    logic [11:0] imml;
    logic [4:0]  rs1;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [2:0]  f3l;
    imm  = r[11:0];
    rs1  = r[16:12];
    rd   = r[21:17];
    f3   = r[24:22];
    f3l  = r[28:26] & LD_F3_MASK;
    imml = {r[31:26], r[5:0]};
    // shift immediates must keep only shamt (and the SRAI bit) to stay legal
    if (f3 == 3'd1) imm = imm & 12'h01F;
    else if (f3 == 3'd5) imm = imm & 12'h41F;
`ifdef STIM_HAZARD_EN
    if (hz_ok && (r[31:30] == 2'b11)) rs1 = prev_rd;
`endif
    if (r[25]) return {imm, rs1, f3, rd, 7'b0010011};
    else return {imml, rs1, f3l, rd, 7'b0000011};
  endfunction

  // next-word datapath; the word currently on instr is the last accepted one
  // at the moment of the accept, so its rd field serves as the hazard history
  always_comb begin
    accept     = instr_valid & instr_ready;
    lfsr_next  = lfsr_step(lfsr);
    first_lfsr = lfsr_step(SEED_INIT);
`ifdef STIM_HAZARD_EN
    word_next  = make_word(lfsr_next, 1'b1, instr[11:7]);
    first_word = make_word(first_lfsr, 1'b0, 5'd0);
`else
    word_next  = make_word(lfsr_next);
    first_word = make_word(first_lfsr);
`endif
  end

  // sequencing FSM with registered instruction port and status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      instr        <= NOP;
      instr_valid  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      issued_count <= 32'd0;
      lfsr         <= SEED_INIT;
      warm_cnt     <= 32'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            issued_count <= 32'd0;
            lfsr         <= SEED_INIT;
            warm_cnt     <= WARM_U;
            if (WARM_U != 32'd0) begin
              state       <= S_WARMUP;
              instr       <= NOP;
              instr_valid <= 1'b1;
              busy        <= 1'b1;
              done        <= 1'b0;
            end else if (NUM_U != 32'd0) begin
              state       <= S_GEN;
              lfsr        <= first_lfsr;
              instr       <= first_word;
              instr_valid <= 1'b1;
              busy        <= 1'b1;
              done        <= 1'b0;
            end else begin
              state       <= S_DONE;
              instr       <= NOP;
              instr_valid <= 1'b0;
              busy        <= 1'b0;
              done        <= 1'b1;
            end
          end
        end
        S_WARMUP: begin
          if (accept) begin
            warm_cnt <= warm_cnt - 32'd1;
            if (warm_cnt == 32'd1) begin
              if (NUM_U != 32'd0) begin
                state <= S_GEN;
                lfsr  <= first_lfsr;
                instr <= first_word;
              end else begin
                state       <= S_DONE;
                instr       <= NOP;
                instr_valid <= 1'b0;
                busy        <= 1'b0;
                done        <= 1'b1;
              end
            end
          end
        end
        S_GEN: begin
          if (accept) begin
            issued_count <= issued_count + 32'd1;
            lfsr         <= lfsr_next;
            if (issued_count == LAST_IDX) begin
              state       <= S_DONE;
              instr       <= NOP;
              instr_valid <= 1'b0;
              busy        <= 1'b0;
              done        <= 1'b1;
            end else begin
              instr <= word_next;
            end
          end
        end
        default: begin
          state       <= S_IDLE;
          instr       <= NOP;
          instr_valid <= 1'b0;
          busy        <= 1'b0;
          done        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sodor5_iltype_stim_gen.sv
// Bench for sodor5_iltype_stim_gen: per-cycle vector table on a small run,
// reset and empty-run corners, and a long random-ready run against a model.
module tb_sodor5_iltype_stim_gen;

  localparam logic [31:0] NOP    = 32'h00000013;
  localparam logic [31:0] M_TAPS = 32'h80200003;
  localparam logic [31:0] C_SEED = 32'd909;
  localparam int          C_WARM = 3;
`ifdef STIM_HAZARD_EN
  localparam int C_NUM = 4096;
  localparam bit HZ    = 1'b1;
`else
  localparam int C_NUM = 1000;
  localparam bit HZ    = 1'b0;
`endif

  // hand-computed words for SEED=1 (lfsr 80200003, C0300002, 60180001, B02C0003)
  localparam logic [31:0] W1 = 32'h80300803;
  localparam logic [31:0] W2 = 32'hC0200C03;
  localparam logic [31:0] W3 = 32'h60100603;
  localparam logic [31:0] W4 = 32'hB0304B03;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        start_a = 1'b0, ready_a = 1'b0;
  logic [31:0] instr_a, cnt_a;
  logic        valid_a, busy_a, done_a;
  logic        start_b = 1'b0, ready_b = 1'b0;
  logic [31:0] instr_b, cnt_b;
  logic        valid_b, busy_b, done_b;
  logic        start_c = 1'b0, ready_c = 1'b0;
  logic [31:0] instr_c, cnt_c;
  logic        valid_c, busy_c, done_c;

  sodor5_iltype_stim_gen #(.SEED(32'd1), .NUM_INSTR(4), .WARMUP(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .instr(instr_a),
    .instr_valid(valid_a), .instr_ready(ready_a), .busy(busy_a), .done(done_a),
    .issued_count(cnt_a));

  sodor5_iltype_stim_gen #(.SEED(32'd5), .NUM_INSTR(0), .WARMUP(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .instr(instr_b),
    .instr_valid(valid_b), .instr_ready(ready_b), .busy(busy_b), .done(done_b),
    .issued_count(cnt_b));

  sodor5_iltype_stim_gen #(.SEED(C_SEED), .NUM_INSTR(C_NUM), .WARMUP(C_WARM)) dut_c (
    .clk(clk), .reset_n(reset_n), .start(start_c), .instr(instr_c),
    .instr_valid(valid_c), .instr_ready(ready_c), .busy(busy_c), .done(done_c),
    .issued_count(cnt_c));

  int checks = 0;
  int errors = 0;
  logic [31:0] words0 [C_NUM];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // bit-wise formulation of the Galois right-shift step
  function automatic logic [31:0] m_step(input logic [31:0] r);
    logic [31:0] n;
    for (int i = 0; i < 31; i++) n[i] = r[i+1] ^ (M_TAPS[i] & r[0]);
    n[31] = M_TAPS[31] & r[0];
    return n;
  endfunction

  function automatic logic [31:0] m_word(input logic [31:0] r, input bit hz_ok,
                                         input logic [4:0] prd);
    logic [11:0] imm, imml;
    logic [4:0]  rs1, rd;
    logic [2:0]  f3, f3l;
    imm  = r[11:0];
    rs1  = r[16:12];
    rd   = r[21:17];
    f3   = r[24:22];
    f3l  = {r[28], 2'b00};
    imml = {r[31:26], r[5:0]};
    if (f3 == 3'd1) imm = {7'd0, imm[4:0]};
    else if (f3 == 3'd5) imm = {1'b0, imm[10], 5'd0, imm[4:0]};
    if (HZ && hz_ok && r[31] && r[30]) rs1 = prd;
    if (r[25]) return {imm, rs1, f3, rd, 7'h13};
    return {imml, rs1, f3l, rd, 7'h03};
  endfunction

  typedef struct {
    logic        start;
    logic        ready;
    logic        valid;
    logic [31:0] instr;
    logic        busy;
    logic        done;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl [14];

  task automatic run_c(input int run, input bit do_stall);
    int n_acc = 0, n_gen = 0, budget = 0, mism = 0, viol = 0, hits = 0, rep = 0;
    bit stalled = 1'b0;
    logic [31:0] r, exp_w, w, c;
    logic [4:0] prd, prd_dut;
    logic v;
    r = C_SEED;
    prd = 5'd0;
    prd_dut = 5'd0;
    start_c = 1'b1;
    @(posedge clk); #1;
    start_c = 1'b0;
    while (n_gen < C_NUM && budget < C_NUM * 8 + 200) begin
      v = valid_c;
      w = instr_c;
      c = cnt_c;
      ready_c = ($urandom_range(0, 3) != 0);
      if (do_stall && !stalled && v && n_acc >= C_WARM && n_gen == C_NUM / 2) begin
        stalled = 1'b1;
        ready_c = 1'b0;
        repeat (5) begin
          @(posedge clk); #1;
          check("stall_valid", {31'd0, valid_c}, 32'd1);
          check("stall_instr", instr_c, w);
          check("stall_count", cnt_c, c);
        end
        ready_c = 1'b1;
      end
      @(posedge clk); #1;
      budget++;
      if (v && ready_c) begin
        if (n_acc < C_WARM) begin
          if (w !== NOP) mism++;
        end else begin
          r = m_step(r);
          exp_w = m_word(r, n_gen != 0, prd);
          prd = exp_w[11:7];
          if (w !== exp_w) mism++;
          if (run == 0) words0[n_gen] = w;
          else if (words0[n_gen] !== w) rep++;
          if (w[6:0] == 7'h13) begin
            if (w[14:12] == 3'd1 && w[31:25] != 7'd0) viol++;
            if (w[14:12] == 3'd5 && w[31:25] != 7'd0 && w[31:25] != 7'h20) viol++;
          end else if (w[6:0] == 7'h03) begin
            if (w[14:12] != 3'd0 && w[14:12] != 3'd4) viol++;
          end else viol++;
          if (n_gen > 0 && w[19:15] == prd_dut) hits++;
          prd_dut = w[11:7];
          n_gen++;
        end
        n_acc++;
      end
    end
    ready_c = 1'b0;
    check("c_words_issued", 32'(n_gen), 32'(C_NUM));
    check("c_model_mismatches", 32'(mism), 32'd0);
    check("c_illegal_words", 32'(viol), 32'd0);
    check("c_done", {31'd0, done_c}, 32'd1);
    check("c_valid_low", {31'd0, valid_c}, 32'd0);
    check("c_count", cnt_c, 32'(C_NUM));
    if (run == 1) check("c_repeat_diffs", 32'(rep), 32'd0);
    if (HZ) begin
      check("c_hazard_low", 32'(hits * 100 >= 20 * (C_NUM - 1)), 32'd1);
      check("c_hazard_high", 32'(hits * 100 <= 30 * (C_NUM - 1)), 32'd1);
    end
  endtask

  initial begin
    //            start ready valid instr busy done cnt
    tbl[0]  = '{1'b1, 1'b0, 1'b1, NOP, 1'b1, 1'b0, 32'd0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, NOP, 1'b1, 1'b0, 32'd0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, NOP, 1'b1, 1'b0, 32'd0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, W1,  1'b1, 1'b0, 32'd0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, W2,  1'b1, 1'b0, 32'd1};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, W2,  1'b1, 1'b0, 32'd1};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, W3,  1'b1, 1'b0, 32'd2};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, W4,  1'b1, 1'b0, 32'd3};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, NOP, 1'b0, 1'b1, 32'd4};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, NOP, 1'b0, 1'b1, 32'd4};
    tbl[10] = '{1'b1, 1'b0, 1'b1, NOP, 1'b1, 1'b0, 32'd0};
    tbl[11] = '{1'b0, 1'b1, 1'b1, NOP, 1'b1, 1'b0, 32'd0};
    tbl[12] = '{1'b0, 1'b1, 1'b1, W1,  1'b1, 1'b0, 32'd0};
    tbl[13] = '{1'b0, 1'b1, 1'b1, W2,  1'b1, 1'b0, 32'd1};

    repeat (3) @(posedge clk);
    #1;
    check("reset_instr", instr_a, NOP);
    check("reset_flags", {29'd0, valid_a, busy_a, done_a}, 32'd0);
    check("reset_count", cnt_a, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      start_a = tbl[i].start;
      ready_a = tbl[i].ready;
      @(posedge clk); #1;
      check($sformatf("vec%0d_flags", i), {29'd0, valid_a, busy_a, done_a},
            {29'd0, tbl[i].valid, tbl[i].busy, tbl[i].done});
      check($sformatf("vec%0d_instr", i), instr_a, tbl[i].instr);
      check($sformatf("vec%0d_count", i), cnt_a, tbl[i].cnt);
    end
    start_a = 1'b0;

    // asynchronous reset mid-GEN, observed before any further clock edge
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_instr", instr_a, NOP);
    check("async_rst_flags", {29'd0, valid_a, busy_a, done_a}, 32'd0);
    check("async_rst_count", cnt_a, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    ready_a = 1'b0;
    @(posedge clk); #1;
    check("idle_after_rst", {29'd0, valid_a, busy_a, done_a}, 32'd0);

    // empty run: no warmup, no instructions
    check("b_idle_done", {31'd0, done_b}, 32'd0);
    start_b = 1'b1;
    ready_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    check("b_done_flags", {29'd0, valid_b, busy_b, done_b}, 32'd1);
    check("b_count", cnt_b, 32'd0);
    check("b_instr", instr_b, NOP);

    run_c(0, 1'b1);
    @(posedge clk); #1;
    run_c(1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
